demultiplex_buffered: RTL and testbench

Buffered 1:2 demultiplexer for the MIPS32 datapath: the distributing counterpart of the 2:1 `Multiplex` select. One producer stream is routed by a 1-bit selector to one of two consumer channels (A for selector 0, B for selector 1). Each channel has its own small FIFO with a valid/ready handshake, so a stalled consumer never blocks the other channel's already-buffered data. It sits where one result source feeds two independent sinks, e.g. register-file write-back vs. store path.

---
 rtl/demultiplex_buffered_pkg.sv | 29 ++
 rtl/demultiplex_buffered_fila_saida.sv | 102 ++++++++++
 rtl/demultiplex_buffered.sv | 92 +++++++++
 tb/tb_demultiplex_buffered.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demultiplex_buffered_pkg.sv
// ---------------------------------------------------------------------------
// demultiplex_buffered_pkg
//
// Purpose: shared constants for the buffered 1:2 demultiplexer and its
// per-channel output FIFO. It holds the default data width, the default
// FIFO depth, and the selector encodings that name the two destination
// channels.
//
// Contents:
//   LARGURA_PADRAO      default data width in bits
//   PROFUNDIDADE_PADRAO default entries per channel FIFO (power of two, >= 2)
//   SEL_A / SEL_B       selector values that route to channel A / channel B
//   larguraContagem()   width of an occupancy counter for a given depth
// ---------------------------------------------------------------------------
package demultiplex_buffered_pkg;

    localparam int LARGURA_PADRAO      = 32;
    localparam int PROFUNDIDADE_PADRAO = 2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // The occupancy counter needs one more bit than the pointers, so that
    // the value "completely full" (count == depth) can be represented.
    function automatic int larguraContagem(input int profundidade);
        return $clog2(profundidade) + 1;
    endfunction

endpackage

// File: rtl/demultiplex_buffered_fila_saida.sv
// ---------------------------------------------------------------------------
// fila_saida
//
// Purpose: a small synchronous FIFO with a valid/ready style interface. One
// instance buffers each output channel of demultiplex_buffered. A word that
// is pushed into an empty FIFO becomes visible on the following cycle; the
// FIFO has no bypass path.
//
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset (clears pointers and count)
//   push_i      write dado_i this cycle (ignored while full)
//   pop_i       consumer takes the head word (ignored while empty)
//   dado_i      word to be written
//   dado_o      head-of-FIFO word (don't-care while valida_o = 0)
//   valida_o    FIFO holds at least one word
//   cheio_o     FIFO holds PROFUNDIDADE words
//   contagem_o  current occupancy, 0 .. PROFUNDIDADE
// ---------------------------------------------------------------------------
module fila_saida
    import demultiplex_buffered_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            push_i,
    input  logic                            pop_i,
    input  logic [LARGURA-1:0]              dado_i,
    output logic [LARGURA-1:0]              dado_o,
    output logic                            valida_o,
    output logic                            cheio_o,
    output logic [$clog2(PROFUNDIDADE):0]   contagem_o
);

    localparam int PW = $clog2(PROFUNDIDADE);
    localparam int CW = PW + 1;

    logic [LARGURA-1:0] memoria_q [PROFUNDIDADE];

    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] contagem_q, contagem_d;

    logic doPush;
    logic doPop;

    assign cheio_o    = (contagem_q == CW'(PROFUNDIDADE));
    assign valida_o   = (contagem_q != '0);
    assign contagem_o = contagem_q;
    assign dado_o     = memoria_q[rdPtr_q];

    // A push into a full FIFO or a pop from an empty one is simply dropped.
    // A full FIFO refuses a push even when it is being popped in the same
    // cycle; the freed slot becomes usable on the next cycle.
    assign doPush = push_i && !cheio_o;
    assign doPop  = pop_i  && valida_o;

    // Next-state for pointers and occupancy. Pointers are exactly log2(depth)
    // bits, so incrementing past the last entry wraps back to zero on its own.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        contagem_d = contagem_q;

        if (doPush) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end

        unique case ({doPush, doPop})
            2'b10:   contagem_d = contagem_q + CW'(1);
            2'b01:   contagem_d = contagem_q - CW'(1);
            default: contagem_d = contagem_q;
        endcase
    end

    // Control state: flushed by reset, so any buffered words are discarded.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            contagem_q <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            contagem_q <= contagem_d;
        end
    end

    // Storage is deliberately not reset: its contents are only observable
    // through dado_o while valida_o is high, and that requires a fresh push.
    always_ff @(posedge clock) begin
        if (doPush) begin
            memoria_q[wrPtr_q] <= dado_i;
        end
    end

endmodule

// File: rtl/demultiplex_buffered.sv
// ---------------------------------------------------------------------------
// demultiplex_buffered
//
// Purpose: buffered 1:2 demultiplexer. A single producer stream is steered
// by `seletor` into one of two output channels (A for 0, B for 1). Each
// channel owns an independent FIFO, so a stalled consumer on one channel
// never blocks words already buffered for the other.
//
// Ports:
//   clock                          rising-edge clock
//   reset_n                        asynchronous active-low reset
//   entrada, seletor               offered word and its destination
//   entrada_valida / entrada_pronta  input handshake
//   saidaA, saidaB                 head-of-FIFO word per channel
//   saidaA_valida, saidaB_valida   channel holds data
//   saidaA_pronta, saidaB_pronta   consumer takes the head word
//   contagemA, contagemB           per-channel occupancy
// ---------------------------------------------------------------------------
module demultiplex_buffered
    import demultiplex_buffered_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [LARGURA-1:0]              entrada,
    input  logic                            seletor,
    input  logic                            entrada_valida,
    output logic                            entrada_pronta,
    output logic [LARGURA-1:0]              saidaA,
    output logic [LARGURA-1:0]              saidaB,
    output logic                            saidaA_valida,
    output logic                            saidaB_valida,
    input  logic                            saidaA_pronta,
    input  logic                            saidaB_pronta,
    output logic [$clog2(PROFUNDIDADE):0]   contagemA,
    output logic [$clog2(PROFUNDIDADE):0]   contagemB
);

    logic cheioA;
    logic cheioB;
    logic pushA;
    logic pushB;
    logic popA;
    logic popB;
    logic aceita;

    // Readiness looks only at the fullness of the selected channel. It never
    // depends on the consumer ready signals, which keeps the input handshake
    // free of a combinational path from the output side.
    assign entrada_pronta = (seletor == SEL_B) ? !cheioB : !cheioA;
    assign aceita         = entrada_valida && entrada_pronta;

    // Only the selected FIFO sees the push; the other one is left untouched.
    assign pushA = aceita && (seletor == SEL_A);
    assign pushB = aceita && (seletor == SEL_B);

    assign popA  = saidaA_valida && saidaA_pronta;
    assign popB  = saidaB_valida && saidaB_pronta;

    fila_saida #(
        .LARGURA      (LARGURA),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_filaA (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_i     (pushA),
        .pop_i      (popA),
        .dado_i     (entrada),
        .dado_o     (saidaA),
        .valida_o   (saidaA_valida),
        .cheio_o    (cheioA),
        .contagem_o (contagemA)
    );

    fila_saida #(
        .LARGURA      (LARGURA),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_filaB (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_i     (pushB),
        .pop_i      (popB),
        .dado_i     (entrada),
        .dado_o     (saidaB),
        .valida_o   (saidaB_valida),
        .cheio_o    (cheioB),
        .contagem_o (contagemB)
    );

endmodule

// File: tb/tb_demultiplex_buffered.sv
// ---------------------------------------------------------------------------
// tb_demultiplex_buffered
//
// Self-checking bench for demultiplex_buffered. Accepted words are queued
// per channel; a monitor pops and compares whenever a channel transfers.
// Directed checks of counts, valids and readiness use hand-computed values.
// ---------------------------------------------------------------------------
module tb_demultiplex_buffered;

    logic        clock;
    logic        reset_n;
    logic [31:0] entrada;
    logic        seletor;
    logic        entrada_valida;
    logic        entrada_pronta;
    logic [31:0] saidaA;
    logic [31:0] saidaB;
    logic        saidaA_valida;
    logic        saidaB_valida;
    logic        saidaA_pronta;
    logic        saidaB_pronta;
    logic [1:0]  contagemA;
    logic [1:0]  contagemB;

    int checks   = 0;
    int failures = 0;

    logic [31:0] expA[$];
    logic [31:0] expB[$];

    demultiplex_buffered #(
        .LARGURA      (32),
        .PROFUNDIDADE (2)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .entrada        (entrada),
        .seletor        (seletor),
        .entrada_valida (entrada_valida),
        .entrada_pronta (entrada_pronta),
        .saidaA         (saidaA),
        .saidaB         (saidaB),
        .saidaA_valida  (saidaA_valida),
        .saidaB_valida  (saidaB_valida),
        .saidaA_pronta  (saidaA_pronta),
        .saidaB_pronta  (saidaB_pronta),
        .contagemA      (contagemA),
        .contagemB      (contagemB)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One comparison: counts it, and reports a mismatch on a single line.
    task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nome, atual, esperado);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Offer one word and hold it until accepted (bounded). The expected
    // output is queued on the chosen channel at the moment of acceptance.
    task automatic applyStimulus(input logic [31:0] dado, input logic sel);
        bit aceito;
        aceito         = 1'b0;
        entrada        = dado;
        seletor        = sel;
        entrada_valida = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (entrada_pronta) begin
                aceito = 1'b1;
                if (sel) expB.push_back(dado);
                else     expA.push_back(dado);
            end
            @(posedge clock);
            #1;
            if (aceito) break;
        end
        entrada_valida = 1'b0;
        if (!aceito) begin
            checkOutput("push_timeout", 32'd0, 32'd1);
        end
    endtask

    // Monitor: sampled on the falling edge, i.e. just before the edge on
    // which a channel transfer takes effect.
    always @(negedge clock) begin
        if (reset_n) begin
            if (saidaA_valida && saidaA_pronta) begin
                if (expA.size() == 0) checkOutput("saidaA_unexpected", saidaA, 32'hxxxx_xxxx);
                else                  checkOutput("saidaA_data", saidaA, expA.pop_front());
            end
            if (saidaB_valida && saidaB_pronta) begin
                if (expB.size() == 0) checkOutput("saidaB_unexpected", saidaB, 32'hxxxx_xxxx);
                else                  checkOutput("saidaB_data", saidaB, expB.pop_front());
            end
        end
    end

    initial begin
        reset_n        = 1'b0;
        entrada        = 32'd0;
        seletor        = 1'b0;
        entrada_valida = 1'b0;
        saidaA_pronta  = 1'b0;
        saidaB_pronta  = 1'b0;

        // Reset state.
        repeat (3) cycle();
        checkOutput("rst_validaA", 32'(saidaA_valida), 32'd0);
        checkOutput("rst_validaB", 32'(saidaB_valida), 32'd0);
        checkOutput("rst_contagemA", 32'(contagemA), 32'd0);
        checkOutput("rst_contagemB", 32'(contagemB), 32'd0);
        reset_n = 1'b1;
        cycle();
        checkOutput("rst_pronta_sel0", 32'(entrada_pronta), 32'd1);
        seletor = 1'b1;
        #1;
        checkOutput("rst_pronta_sel1", 32'(entrada_pronta), 32'd1);

        // Routing: A word first, then B word; no bypass, no cross-leak.
        saidaA_pronta = 1'b1;
        saidaB_pronta = 1'b1;
        applyStimulus(32'h0000_00AA, 1'b0);
        checkOutput("route_validaA", 32'(saidaA_valida), 32'd1);
        checkOutput("route_saidaA", saidaA, 32'h0000_00AA);
        checkOutput("route_validaB_idle", 32'(saidaB_valida), 32'd0);
        applyStimulus(32'h0000_00BB, 1'b1);
        checkOutput("route_validaB", 32'(saidaB_valida), 32'd1);
        checkOutput("route_saidaB", saidaB, 32'h0000_00BB);
        checkOutput("route_validaA_drained", 32'(saidaA_valida), 32'd0);
        cycle();
        checkOutput("route_validaB_drained", 32'(saidaB_valida), 32'd0);

        // Full and backpressure on A.
        saidaA_pronta = 1'b0;
        applyStimulus(32'h1, 1'b0);
        applyStimulus(32'h2, 1'b0);
        checkOutput("full_contagemA", 32'(contagemA), 32'd2);
        seletor = 1'b0;
        #1;
        checkOutput("full_pronta_sel0", 32'(entrada_pronta), 32'd0);
        seletor = 1'b1;
        #1;
        checkOutput("full_pronta_sel1", 32'(entrada_pronta), 32'd1);
        applyStimulus(32'h3, 1'b1);
        checkOutput("full_contagemB", 32'(contagemB), 32'd1);
        cycle();
        checkOutput("full_contagemB_drained", 32'(contagemB), 32'd0);

        // Pop while full: the freed slot is usable only on the next cycle.
        entrada        = 32'h4;
        seletor        = 1'b0;
        entrada_valida = 1'b1;
        saidaA_pronta  = 1'b1;
        @(negedge clock);
        checkOutput("popfull_pronta_same", 32'(entrada_pronta), 32'd0);
        cycle();
        saidaA_pronta  = 1'b0;
        entrada_valida = 1'b0;
        #1;
        checkOutput("popfull_pronta_next", 32'(entrada_pronta), 32'd1);
        checkOutput("popfull_contagemA", 32'(contagemA), 32'd1);
        applyStimulus(32'h4, 1'b0);
        checkOutput("popfull_contagemA_refill", 32'(contagemA), 32'd2);
        saidaA_pronta = 1'b1;
        repeat (3) cycle();
        checkOutput("popfull_contagemA_empty", 32'(contagemA), 32'd0);

        // Wrap-around streaming into B at one word per cycle.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'h10 + 32'(i), 1'b1);
            checkOutput("wrap_contagemB", 32'(contagemB), 32'd1);
        end
        cycle();
        checkOutput("wrap_contagemB_end", 32'(contagemB), 32'd0);

        // Simultaneous push to A with pops on A and B.
        saidaA_pronta = 1'b0;
        saidaB_pronta = 1'b0;
        applyStimulus(32'h20, 1'b0);
        applyStimulus(32'h30, 1'b1);
        checkOutput("simul_contagemA_pre", 32'(contagemA), 32'd1);
        checkOutput("simul_contagemB_pre", 32'(contagemB), 32'd1);
        entrada        = 32'h21;
        seletor        = 1'b0;
        entrada_valida = 1'b1;
        saidaA_pronta  = 1'b1;
        saidaB_pronta  = 1'b1;
        expA.push_back(32'h21);
        cycle();
        entrada_valida = 1'b0;
        saidaA_pronta  = 1'b0;
        saidaB_pronta  = 1'b0;
        checkOutput("simul_contagemA", 32'(contagemA), 32'd1);
        checkOutput("simul_contagemB", 32'(contagemB), 32'd0);
        checkOutput("simul_saidaA", saidaA, 32'h21);
        saidaA_pronta = 1'b1;
        cycle();
        saidaA_pronta = 1'b0;

        // Reset mid-stream flushes both channels.
        applyStimulus(32'h50, 1'b0);
        applyStimulus(32'h60, 1'b1);
        checkOutput("midrst_contagemA_pre", 32'(contagemA), 32'd1);
        reset_n = 1'b0;
        #1;
        expA.delete();
        expB.delete();
        checkOutput("midrst_validaA", 32'(saidaA_valida), 32'd0);
        checkOutput("midrst_validaB", 32'(saidaB_valida), 32'd0);
        checkOutput("midrst_contagemA", 32'(contagemA), 32'd0);
        checkOutput("midrst_contagemB", 32'(contagemB), 32'd0);
        cycle();
        reset_n = 1'b1;
        cycle();
        seletor = 1'b0;
        #1;
        checkOutput("midrst_pronta", 32'(entrada_pronta), 32'd1);
        saidaA_pronta = 1'b1;
        applyStimulus(32'h77, 1'b0);
        checkOutput("midrst_saidaA", saidaA, 32'h77);
        repeat (3) cycle();

        // Every accepted word must have come out.
        checkOutput("final_expA_empty", 32'(expA.size()), 32'd0);
        checkOutput("final_expB_empty", 32'(expB.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
